// File: rtl/glyph_pkg.sv
// rtl/glyph_pkg.sv - shared defaults, FSM states, width helper and 4x5 reset font for glyph_store
package glyph_pkg;

  localparam int DEF_GLYPH_W    = 4;
  localparam int DEF_GLYPH_H    = 5;
  localparam int DEF_NUM_GLYPHS = 36;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RELOAD = 1'b1
  } glyph_state_e;

  // Index width for a range of n values; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Glyph i at bits [(i+1)*20-1 : i*20]; within a glyph, row y is nibble y and
  // bit x of that nibble is pixel x (x=0 is the leftmost column).
  // Glyph order A..Z then 0..9; the literal below lists the last glyph first.
  localparam logic [DEF_NUM_GLYPHS*DEF_GLYPH_W*DEF_GLYPH_H-1:0] FONT_4X5 = {
    20'h68E96, 20'h69696, 20'h2248F, 20'h69716, 20'h7871F,  // 9 8 7 6 5
    20'h88F99, 20'h78687, 20'hF2496, 20'h72232, 20'h69BD6,  // 4 3 2 1 0
    20'hF168F, 20'h22255, 20'h99699, 20'h9FF99, 20'h25999,  // Z Y X W V
    20'h69999, 20'h22227, 20'h7861E, 20'h95797, 20'hED996,  // U T S R Q
    20'h11797, 20'h69996, 20'h99DB9, 20'h99FF9, 20'hF1111,  // P O N M L
    20'h95359, 20'h6988C, 20'h72227, 20'h99F99, 20'hE9D1E,  // K J I H G
    20'h1171F, 20'hF171F, 20'h79997, 20'hE111E, 20'h79797,  // F E D C B
    20'h99F96                                               // A
  };

endpackage

// File: rtl/glyph_cell.sv
// rtl/glyph_cell.sv - one glyph bitmap: pixel write, whole-glyph reload and row mux
module glyph_cell
  import glyph_pkg::*;
#(
  parameter int GLYPH_W = DEF_GLYPH_W,
  parameter int GLYPH_H = DEF_GLYPH_H,
  parameter logic [GLYPH_W*GLYPH_H-1:0] INIT = '0,
  localparam int XW = width_of(GLYPH_W),
  localparam int YW = width_of(GLYPH_H)
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [XW-1:0]      wr_x,
  input  logic [YW-1:0]      wr_y,
  input  logic               wr_data,
  input  logic               load,
  input  logic [YW-1:0]      rd_y,
  output logic [GLYPH_W-1:0] rd_row
);

  logic [GLYPH_W*GLYPH_H-1:0] bits_q;

  // Pixel storage: reset and reload both restore the font bitmap; otherwise one pixel may change.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      bits_q <= INIT;
    end else if (load) begin
      bits_q <= INIT;
    end else if (wr_en) begin
      for (int y = 0; y < GLYPH_H; y++) begin
        for (int x = 0; x < GLYPH_W; x++) begin
          if (wr_y == YW'(y) && wr_x == XW'(x)) begin
            bits_q[y*GLYPH_W+x] <= wr_data;
          end
        end
      end
    end
  end

  // Row select; a row index past the glyph height reads as zero.
  always_comb begin
    rd_row = '0;
    for (int y = 0; y < GLYPH_H; y++) begin
      if (rd_y == YW'(y)) begin
        rd_row = bits_q[y*GLYPH_W +: GLYPH_W];
      end
    end
  end

endmodule

// File: rtl/glyph_store.sv
// rtl/glyph_store.sv - writable glyph store with row reads and font reload; optional GLYPH_STORE_LOCK_EN
module glyph_store
  import glyph_pkg::*;
#(
  parameter int GLYPH_W    = DEF_GLYPH_W,
  parameter int GLYPH_H    = DEF_GLYPH_H,
  parameter int NUM_GLYPHS = DEF_NUM_GLYPHS,
  parameter logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0] RESET_FONT = FONT_4X5,
  localparam int IDX_W = width_of(NUM_GLYPHS),
  localparam int XW    = width_of(GLYPH_W),
  localparam int YW    = width_of(GLYPH_H)
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_glyph,
  input  logic [XW-1:0]      wr_x,
  input  logic [YW-1:0]      wr_y,
  input  logic               wr_data,
  input  logic               reload,
  output logic               busy,
  input  logic               rd_req,
  output logic               rd_ready,
  input  logic [IDX_W-1:0]   rd_glyph,
  input  logic [YW-1:0]      rd_y,
  output logic               rd_valid,
  output logic [GLYPH_W-1:0] rd_row
`ifdef GLYPH_STORE_LOCK_EN
  ,
  input  logic               lock_we,
  input  logic [IDX_W-1:0]   lock_glyph,
  input  logic               lock_val
`endif
);

  localparam int GBITS = GLYPH_W * GLYPH_H;

  glyph_state_e       state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [GLYPH_W-1:0] rows [NUM_GLYPHS];
  logic [GLYPH_W-1:0] sel_row;
  logic               wr_in_range;
  logic               wr_locked;
  logic               wr_ok;
  logic               rd_accept;

  assign busy      = (state_q == ST_RELOAD);
  assign rd_ready  = !busy;
  assign rd_accept = rd_req && !busy;

  assign wr_in_range = (int'(wr_glyph) < NUM_GLYPHS) && (int'(wr_x) < GLYPH_W) &&
                       (int'(wr_y) < GLYPH_H);

`ifdef GLYPH_STORE_LOCK_EN
  logic [NUM_GLYPHS-1:0] lock_q;

  // Lock bits follow lock_we at any time, including during reload.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      lock_q <= '0;
    end else if (lock_we && int'(lock_glyph) < NUM_GLYPHS) begin
      lock_q[lock_glyph] <= lock_val;
    end
  end

  // Lock state of the write target as registered, so a same-cycle lock change does not apply yet.
  always_comb begin
    wr_locked = 1'b0;
    for (int g = 0; g < NUM_GLYPHS; g++) begin
      if (wr_glyph == IDX_W'(g)) begin
        wr_locked = lock_q[g];
      end
    end
  end
`else
  assign wr_locked = 1'b0;
`endif

  assign wr_ok = wr_en && !busy && wr_in_range && !wr_locked;

  // Reload sequencer state and glyph counter.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reload walks one glyph per cycle and returns to idle after the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (reload) begin
          state_d = ST_RELOAD;
          cnt_d   = '0;
        end
      end
      ST_RELOAD: begin
        if (cnt_q == IDX_W'(NUM_GLYPHS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_GLYPHS; g++) begin : g_cell
    glyph_cell #(
      .GLYPH_W (GLYPH_W),
      .GLYPH_H (GLYPH_H),
      .INIT    (RESET_FONT[g*GBITS +: GBITS])
    ) u_cell (
      .clock   (clock),
      .rst     (rst),
      .wr_en   (wr_ok && (wr_glyph == IDX_W'(g))),
      .wr_x    (wr_x),
      .wr_y    (wr_y),
      .wr_data (wr_data),
      .load    (busy && (cnt_q == IDX_W'(g))),
      .rd_y    (rd_y),
      .rd_row  (rows[g])
    );
  end

  // Glyph select for reads; an index past the last glyph reads as zero.
  always_comb begin
    sel_row = '0;
    for (int g = 0; g < NUM_GLYPHS; g++) begin
      if (rd_glyph == IDX_W'(g)) begin
        sel_row = rows[g];
      end
    end
  end

  // Read output register: one-cycle latency, row held while no read completes.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_row   <= '0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_row <= sel_row;
      end
    end
  end

endmodule

// File: tb/tb_glyph_store.sv
// tb/tb_glyph_store.sv - randomized scoreboard bench for glyph_store
module tb_glyph_store;
  import glyph_pkg::*;

  localparam int GW = DEF_GLYPH_W;
  localparam int GH = DEF_GLYPH_H;
  localparam int NG = DEF_NUM_GLYPHS;
  localparam int GB = GW * GH;
  localparam int IW = width_of(NG);
  localparam int XW = width_of(GW);
  localparam int YW = width_of(GH);

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_glyph = '0;
  logic [XW-1:0] wr_x = '0;
  logic [YW-1:0] wr_y = '0;
  logic          wr_data = 1'b0;
  logic          reload = 1'b0;
  logic          busy;
  logic          rd_req = 1'b0;
  logic          rd_ready;
  logic [IW-1:0] rd_glyph = '0;
  logic [YW-1:0] rd_y = '0;
  logic          rd_valid;
  logic [GW-1:0] rd_row;
`ifdef GLYPH_STORE_LOCK_EN
  logic          lock_we = 1'b0;
  logic [IW-1:0] lock_glyph = '0;
  logic          lock_val = 1'b0;
`endif

  glyph_store dut (
    .clock    (clock),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_glyph (wr_glyph),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_data  (wr_data),
    .reload   (reload),
    .busy     (busy),
    .rd_req   (rd_req),
    .rd_ready (rd_ready),
    .rd_glyph (rd_glyph),
    .rd_y     (rd_y),
    .rd_valid (rd_valid),
    .rd_row   (rd_row)
`ifdef GLYPH_STORE_LOCK_EN
    ,
    .lock_we    (lock_we),
    .lock_glyph (lock_glyph),
    .lock_val   (lock_val)
`endif
  );

  always #20 clock = ~clock;

  // Reference model: glyph bitmaps as plain arrays, reload modelled as one bulk restore.
  logic [NG*GB-1:0] font_v;
  logic [GB-1:0]    mdl [NG];
  bit               m_lock [NG];
  int               busy_left;
  bit               exp_valid;
  logic [GW-1:0]    exp_q [$];
  logic [GW-1:0]    last_row;
  int               vectors = 0;
  int               miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < NG; g++) begin
      mdl[g]    = font_v[g*GB +: GB];
      m_lock[g] = 1'b0;
    end
    busy_left = 0;
    exp_valid = 1'b0;
    exp_q.delete();
    last_row  = '0;
  endtask

  function automatic logic [GW-1:0] ref_row(input int g, input int y);
    if (g >= NG || y >= GH) return '0;
    return mdl[g][y*GW +: GW];
  endfunction

  // One clock: evaluate the spec rules on the current inputs, then commit after the edge.
  task automatic tick();
    bit            bz, acc, do_wr, do_rl, do_lk;
    int            g, x, y, lg;
    logic [GW-1:0] r;
    bit            d, lv;
    bz    = (busy_left > 0);
    g     = int'(wr_glyph);
    x     = int'(wr_x);
    y     = int'(wr_y);
    d     = wr_data;
    acc   = rd_req && !bz;
    r     = ref_row(int'(rd_glyph), int'(rd_y));
    do_wr = wr_en && !bz && g < NG && x < GW && y < GH;
    if (do_wr && m_lock[g]) do_wr = 1'b0;
    do_rl = reload && !bz;
    do_lk = 1'b0;
    lg    = 0;
    lv    = 1'b0;
`ifdef GLYPH_STORE_LOCK_EN
    lg    = int'(lock_glyph);
    lv    = lock_val;
    do_lk = lock_we && lg < NG;
`endif
    @(posedge clock);
    if (acc) exp_q.push_back(r);
    exp_valid = acc;
    if (do_wr) mdl[g][y*GW+x] = d;
    if (bz) busy_left--;
    if (do_rl) begin
      busy_left = NG;
      for (int k = 0; k < NG; k++) mdl[k] = font_v[k*GB +: GB];
    end
    if (do_lk) m_lock[lg] = lv;
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rd_req = 1'b0;
    reload = 1'b0;
`ifdef GLYPH_STORE_LOCK_EN
    lock_we = 1'b0;
`endif
  endtask

  task automatic read_all();
    idle();
    for (int g = 0; g < NG; g++) begin
      for (int y = 0; y < GH; y++) begin
        rd_req   = 1'b1;
        rd_glyph = IW'(g);
        rd_y     = YW'(y);
        tick();
      end
    end
    idle();
    tick();
  endtask

  task automatic write_px(input int g, input int x, input int y, input bit d);
    wr_en    = 1'b1;
    wr_glyph = IW'(g);
    wr_x     = XW'(x);
    wr_y     = YW'(y);
    wr_data  = d;
  endtask

  // Monitor: compares every cycle's outputs against what the model says must be showing.
  always @(negedge clock) begin
    logic [GW-1:0] e;
    if (!rst) begin
      check("busy", {31'd0, busy}, {31'd0, busy_left > 0});
      check("rd_ready", {31'd0, rd_ready}, {31'd0, busy_left == 0});
      check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_row", 32'(rd_row), 32'(e));
          last_row = e;
        end
      end else begin
        check("rd_row_hold", 32'(rd_row), 32'(last_row));
      end
    end
  end

  initial begin
    int busy_cnt;
    logic [GW-1:0] orig;
    font_v = FONT_4X5;
    model_reset();

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset_rd_row", 32'(rd_row), 32'd0);
    @(posedge clock);
    #1 rst = 1'b0;

    // Glyph 0 rows after reset
    for (int y = 0; y < GH; y++) begin
      rd_req = 1'b1; rd_glyph = '0; rd_y = YW'(y);
      tick();
    end
    idle(); tick();

    // Single pixel flip with same-cycle read of that row, then re-read
    orig = ref_row(5, 3);
    write_px(5, 2, 3, ~orig[2]);
    rd_req = 1'b1; rd_glyph = IW'(5); rd_y = YW'(3);
    tick();
    wr_en = 1'b0;
    tick();
    idle(); tick();

    // Random writes, then reload with a held read, a blocked write and an ignored reload
    for (int i = 0; i < 10; i++) begin
      write_px($urandom_range(0, NG-1), $urandom_range(0, GW-1), $urandom_range(0, GH-1),
               1'($urandom));
      rd_req = 1'($urandom); rd_glyph = IW'($urandom_range(0, NG-1));
      rd_y = YW'($urandom_range(0, GH-1));
      tick();
    end
    idle();
    reload = 1'b1; rd_req = 1'b1; rd_glyph = IW'(12); rd_y = YW'(2);
    busy_cnt = 0;
    tick();
    busy_cnt += int'(busy);
    reload = 1'b0;
    for (int i = 0; i < 40; i++) begin
      wr_en  = (i == 5);
      reload = (i == 10);
      if (i == 5) write_px(0, 0, 0, ~font_v[0]);
      tick();
      busy_cnt += int'(busy);
    end
    check("reload_busy_cycles", 32'(busy_cnt), 32'(NG));
    read_all();

    // Out-of-range writes and reads
    write_px(40, 1, 1, 1'b1); tick();
    write_px(8, 1, 6, 1'b1); tick();
    write_px(63, 0, 0, 1'b1); tick();
    wr_en = 1'b0;
    rd_req = 1'b1; rd_glyph = IW'(40); rd_y = YW'(0); tick();
    rd_glyph = IW'(8); rd_y = YW'(5); tick();
    rd_glyph = IW'(63); rd_y = YW'(7); tick();
    read_all();

    // Mixed random traffic
    for (int i = 0; i < 400; i++) begin
      wr_en    = 1'($urandom);
      wr_glyph = IW'($urandom_range(0, NG+3));
      wr_x     = XW'($urandom);
      wr_y     = YW'($urandom_range(0, GH));
      wr_data  = 1'($urandom);
      rd_req   = ($urandom_range(0, 9) < 6);
      rd_glyph = IW'($urandom_range(0, NG+3));
      rd_y     = YW'($urandom_range(0, GH));
      reload   = ($urandom_range(0, 99) == 0);
      tick();
    end
    read_all();

`ifdef GLYPH_STORE_LOCK_EN
    // Locks: locked glyph rejects writes, unlock re-enables, reload keeps the lock
    lock_we = 1'b1; lock_glyph = IW'(7); lock_val = 1'b1;
    write_px(7, 1, 1, ~font_v[7*GB + GW + 1]);
    tick();
    lock_we = 1'b0; tick();
    wr_en = 1'b0; rd_req = 1'b1; rd_glyph = IW'(7); rd_y = YW'(1); tick();
    lock_we = 1'b1; lock_val = 1'b0; rd_req = 1'b0; tick();
    lock_we = 1'b0; write_px(7, 1, 1, ~font_v[7*GB + GW + 1]); tick();
    wr_en = 1'b0; rd_req = 1'b1; tick();
    lock_we = 1'b1; lock_val = 1'b1; rd_req = 1'b0; tick();
    idle(); reload = 1'b1; tick();
    reload = 1'b0;
    repeat (NG + 2) tick();
    write_px(7, 2, 2, 1'b1); tick();
    write_px(7, 2, 2, 1'b0); tick();
    idle();
    read_all();
`endif

    // Reset in the middle of a reload
    idle();
    write_px(3, 0, 4, ~font_v[3*GB + 4*GW]); tick();
    idle(); reload = 1'b1; tick();
    reload = 1'b0; rd_req = 1'b1; rd_glyph = IW'(3); rd_y = YW'(4);
    repeat (11) tick();
    rst = 1'b1;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("midreset_rd_row", 32'(rd_row), 32'd0);
    idle();
    model_reset();
    @(posedge clock);
    #1 rst = 1'b0;
    read_all();

    idle(); tick(); tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
